// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the two-port asynchronous SRAM arbiter.
// Holds the sequencer state encoding, the grant encoding and the
// access-phase counter width. It also holds the byte-enable
// normalisation helper used when a port B request is latched.
package sram_arbiter_pkg;

    localparam int WAIT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_ACCESS  = 3'd2,
        ST_RECOVER = 3'd3,
        ST_DONE    = 3'd4
    } arb_state_t;

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_t;

    // A request with no byte lanes selected is taken as a full-word access.
    function automatic logic [1:0] coerce_be(input logic [1:0] be);
        logic [1:0] res;
        if (be == 2'b00) begin
            res = 2'b11;
        end else begin
            res = be;
        end
        return res;
    endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester-side bus of the SRAM arbiter.
// Port A: read-only fetch port (a_req/a_addr in, a_ack/a_rdata out).
// Port B: read/write port (b_req/b_we/b_be/b_addr/b_wdata in,
//         b_ack/b_rdata out).
// The master modport is the requester view. The slave modport is the
// arbiter view.
interface sram_arbiter_if;
    logic        a_req;
    logic [20:0] a_addr;
    logic        a_ack;
    logic [15:0] a_rdata;
    logic        b_req;
    logic        b_we;
    logic [1:0]  b_be;
    logic [20:0] b_addr;
    logic [15:0] b_wdata;
    logic        b_ack;
    logic [15:0] b_rdata;

    modport master (
        output a_req, a_addr, b_req, b_we, b_be, b_addr, b_wdata,
        input  a_ack, a_rdata, b_ack, b_rdata
    );

    modport slave (
        input  a_req, a_addr, b_req, b_we, b_be, b_addr, b_wdata,
        output a_ack, a_rdata, b_ack, b_rdata
    );
endinterface

// File: rtl/sram_arb_pick.sv
// Grant selection for the SRAM arbiter.
// Port A wins by fixed priority unless it has already taken A_BURST_MAX
// consecutive grants while port B was waiting. In that case port B is
// granted next.
// Ports:
//   clock, reset   : system clock, async active-high reset
//   arb_en_i       : the sequencer is idle and will act on this grant
//   a_req_i/b_req_i: requests
//   grant_valid_o  : at least one request is present
//   grant_o        : chosen port
module sram_arb_pick
    import sram_arbiter_pkg::*;
#(
    parameter int A_BURST_MAX = 4
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   arb_en_i,
    input  logic   a_req_i,
    input  logic   b_req_i,
    output logic   grant_valid_o,
    output grant_t grant_o
);

    localparam logic [WAIT_W-1:0] BURST_MAX_C = WAIT_W'(A_BURST_MAX);

    logic [WAIT_W-1:0] burst_q;
    logic [WAIT_W-1:0] burst_d;

    // Fixed-priority pick with the starvation override for port B.
    always_comb begin
        grant_valid_o = a_req_i | b_req_i;
        if (a_req_i && !(b_req_i && (burst_q == BURST_MAX_C))) begin
            grant_o = GRANT_A;
        end else if (b_req_i) begin
            grant_o = GRANT_B;
        end else begin
            grant_o = GRANT_A;
        end
    end

    // Count A grants taken while B waits; any idle cycle without B clears it.
    always_comb begin
        burst_d = burst_q;
        if (arb_en_i) begin
            if (!b_req_i || (grant_o == GRANT_B)) begin
                burst_d = '0;
            end else begin
                burst_d = burst_q + 4'd1;
            end
        end else begin
            burst_d = burst_q;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            burst_q <= '0;
        end else begin
            burst_q <= burst_d;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter and cycle sequencer for a 16-bit asynchronous SRAM.
// It runs every SRAM cycle as IDLE -> SETUP -> ACCESS (WAIT_CYCLES) ->
// [RECOVER for writes] -> DONE. All pad outputs come from registers.
// Ports:
//   clock, reset : system clock, async active-high reset
//   bus          : requester bus (slave view), ports A and B
//   ram_*        : SRAM pads (address, tri-state data, active-low strobes)
//   busy         : high whenever the sequencer is outside IDLE
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int A_BURST_MAX = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    sram_arbiter_if.slave        bus,
    output logic [20:0]          ram_addr_o,
    inout  wire  [15:0]          ram_data_io,
    output logic                 ram_we_n_o,
    output logic                 ram_oe_n_o,
    output logic                 ram_ce_n_o,
    output logic                 ram_lb_n_o,
    output logic                 ram_ub_n_o,
    output logic                 busy
);

    arb_state_t        state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    grant_t            gnt_q, gnt_d;
    logic              we_q, we_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              drive_q, drive_d;
    logic [20:0]       addr_q, addr_d;
    logic              we_n_q, we_n_d, oe_n_q, oe_n_d, ce_n_q, ce_n_d;
    logic              lb_n_q, lb_n_d, ub_n_q, ub_n_d;
    logic              a_ack_q, a_ack_d, b_ack_q, b_ack_d;
    logic [15:0]       a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic              busy_q, busy_d;

    logic              grant_valid_s;
    grant_t            grant_s;
    logic [20:0]       sel_addr_s;
    logic              sel_we_s;
    logic [1:0]        sel_be_s;
    logic [15:0]       sel_wdata_s;

    sram_arb_pick #(.A_BURST_MAX(A_BURST_MAX)) u_pick (
        .clock         (clock),
        .reset         (reset),
        .arb_en_i      (state_q == ST_IDLE),
        .a_req_i       (bus.a_req),
        .b_req_i       (bus.b_req),
        .grant_valid_o (grant_valid_s),
        .grant_o       (grant_s)
    );

    // Mux the winning port's request fields ahead of the SETUP latch.
    always_comb begin
        if (grant_s == GRANT_B) begin
            sel_addr_s  = bus.b_addr;
            sel_we_s    = bus.b_we;
            sel_be_s    = coerce_be(bus.b_be);
            sel_wdata_s = bus.b_wdata;
        end else begin
            sel_addr_s  = bus.a_addr;
            sel_we_s    = 1'b0;
            sel_be_s    = 2'b11;
            sel_wdata_s = 16'h0000;
        end
    end

    // Sequencer next state. Pad values are computed for the state being
    // entered, so the registered pads are already correct in that state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        drive_d   = drive_q;
        addr_d    = addr_q;
        we_n_d    = we_n_q;
        oe_n_d    = oe_n_q;
        ce_n_d    = ce_n_q;
        lb_n_d    = lb_n_q;
        ub_n_d    = ub_n_q;
        a_ack_d   = 1'b0;
        b_ack_d   = 1'b0;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid_s) begin
                    state_d = ST_SETUP;
                    gnt_d   = grant_s;
                    we_d    = sel_we_s;
                    wdata_d = sel_wdata_s;
                    addr_d  = sel_addr_s;
                    ce_n_d  = 1'b0;
                    if (sel_we_s) begin
                        oe_n_d  = 1'b1;
                        drive_d = 1'b1;
                        lb_n_d  = ~sel_be_s[0];
                        ub_n_d  = ~sel_be_s[1];
                    end else begin
                        oe_n_d  = 1'b0;
                        drive_d = 1'b0;
                        lb_n_d  = 1'b0;
                        ub_n_d  = 1'b0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
                cnt_d   = WAIT_W'(WAIT_CYCLES - 1);
                we_n_d  = ~we_q;
            end
            ST_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    if (we_q) begin
                        // Strobe ends; address and data stay for hold time.
                        state_d = ST_RECOVER;
                        we_n_d  = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                        ce_n_d  = 1'b1;
                        oe_n_d  = 1'b1;
                        lb_n_d  = 1'b1;
                        ub_n_d  = 1'b1;
                        a_ack_d = (gnt_q == GRANT_A);
                        b_ack_d = (gnt_q == GRANT_B);
                        if (gnt_q == GRANT_A) begin
                            a_rdata_d = ram_data_io;
                        end else begin
                            b_rdata_d = ram_data_io;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RECOVER: begin
                state_d = ST_DONE;
                ce_n_d  = 1'b1;
                oe_n_d  = 1'b1;
                lb_n_d  = 1'b1;
                ub_n_d  = 1'b1;
                drive_d = 1'b0;
                a_ack_d = (gnt_q == GRANT_A);
                b_ack_d = (gnt_q == GRANT_B);
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                we_n_d  = 1'b1;
                oe_n_d  = 1'b1;
                ce_n_d  = 1'b1;
                lb_n_d  = 1'b1;
                ub_n_d  = 1'b1;
                drive_d = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State, latched request and pad registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            gnt_q     <= GRANT_A;
            we_q      <= 1'b0;
            wdata_q   <= 16'h0000;
            drive_q   <= 1'b0;
            addr_q    <= 21'h000000;
            we_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            ce_n_q    <= 1'b1;
            lb_n_q    <= 1'b1;
            ub_n_q    <= 1'b1;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_rdata_q <= 16'h0000;
            b_rdata_q <= 16'h0000;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            drive_q   <= drive_d;
            addr_q    <= addr_d;
            we_n_q    <= we_n_d;
            oe_n_q    <= oe_n_d;
            ce_n_q    <= ce_n_d;
            lb_n_q    <= lb_n_d;
            ub_n_q    <= ub_n_d;
            a_ack_q   <= a_ack_d;
            b_ack_q   <= b_ack_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
            busy_q    <= busy_d;
        end
    end

    assign ram_data_io = drive_q ? wdata_q : 16'hzzzz;
    assign ram_addr_o  = addr_q;
    assign ram_we_n_o  = we_n_q;
    assign ram_oe_n_o  = oe_n_q;
    assign ram_ce_n_o  = ce_n_q;
    assign ram_lb_n_o  = lb_n_q;
    assign ram_ub_n_o  = ub_n_q;
    assign busy        = busy_q;
    assign bus.a_ack   = a_ack_q;
    assign bus.b_ack   = b_ack_q;
    assign bus.a_rdata = a_rdata_q;
    assign bus.b_rdata = b_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter. It includes a behavioural SRAM
// model and a scoreboard queue of expected acks that a monitor pops.
module tb_sram_arbiter;
    import sram_arbiter_pkg::*;

    localparam int W    = 2;
    localparam int BMAX = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    sram_arbiter_if bus_if();
    logic [20:0] ram_addr;
    wire  [15:0] ram_data;
    logic ram_we_n, ram_oe_n, ram_ce_n, ram_lb_n, ram_ub_n, busy;

    sram_arbiter #(.WAIT_CYCLES(W), .A_BURST_MAX(BMAX)) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus_if),
        .ram_addr_o  (ram_addr),
        .ram_data_io (ram_data),
        .ram_we_n_o  (ram_we_n),
        .ram_oe_n_o  (ram_oe_n),
        .ram_ce_n_o  (ram_ce_n),
        .ram_lb_n_o  (ram_lb_n),
        .ram_ub_n_o  (ram_ub_n),
        .busy        (busy)
    );

    // SRAM model: preload while reset is high, byte-lane writes while WE is low.
    logic [15:0] mem [0:255];
    assign ram_data = (!ram_ce_n && !ram_oe_n && ram_we_n) ? mem[ram_addr[7:0]] : 16'hzzzz;

    always @(negedge clock) begin
        if (reset) begin
            mem[8'h10] <= 16'hA0A0;
            mem[8'h20] <= 16'hB0B0;
            mem[8'h23] <= 16'h55AA;
            mem[8'h30] <= 16'hC3C3;
            mem[8'h50] <= 16'h0000;
        end else if (!ram_ce_n && !ram_we_n) begin
            if (!ram_lb_n) mem[ram_addr[7:0]][7:0]  <= ram_data[7:0];
            if (!ram_ub_n) mem[ram_addr[7:0]][15:8] <= ram_data[15:8];
        end
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic        port;   // 0 = A, 1 = B
        logic [15:0] data;
        int          cyc;    // expected ack cycle, -1 = not checked
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int n_vec = 0;
    int n_err = 0;
    logic [15:0] last_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every ack must match the oldest expected entry.
    always @(negedge clock) begin
        if (bus_if.a_ack || bus_if.b_ack) begin
            if (bus_if.a_ack && bus_if.b_ack) begin
                n_vec++;
                n_err++;
                $display("FAIL dual_ack: got both acks at cycle %0d, want one", cyc);
            end
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_ack: got a_ack=%0b b_ack=%0b at cycle %0d, want none",
                         bus_if.a_ack, bus_if.b_ack, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("ack_port", {31'd0, bus_if.b_ack}, {31'd0, mon_e.port});
                check("ack_rdata", {16'd0, (mon_e.port ? bus_if.b_rdata : bus_if.a_rdata)},
                      {16'd0, mon_e.data});
                if (mon_e.cyc >= 0) check("ack_latency", cyc, mon_e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic port, input logic [15:0] data, input int c);
        exp_t e;
        e.port = port;
        e.data = data;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    // Wait for the given port's ack while observing the pads.
    task automatic wait_ack(input logic port, output int we_low, output logic [1:0] lanes_n,
                            output logic drove);
        logic got;
        got = 1'b0;
        we_low = 0;
        lanes_n = 2'b11;
        drove = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (!ram_we_n) we_low++;
            if (!ram_ce_n) lanes_n = lanes_n & {ram_ub_n, ram_lb_n};
            if (dut.drive_q) drove = 1'b1;
            got = port ? bus_if.b_ack : bus_if.a_ack;
            if (got) break;
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL ack_timeout: got no ack on port %0d within 40 cycles, want ack", port);
        end
    endtask

    int          we_low;
    logic [1:0]  lanes_n;
    logic        drove;
    int          acks;

    initial begin
        bus_if.a_req   = 1'b1;
        bus_if.a_addr  = 21'h000010;
        bus_if.b_req   = 1'b1;
        bus_if.b_we    = 1'b0;
        bus_if.b_be    = 2'b11;
        bus_if.b_addr  = 21'h000020;
        bus_if.b_wdata = 16'h0000;

        // Reset with both requests high: pads idle, bus released, no acks.
        @(negedge clock);
        @(negedge clock);
        check("rst_we_n", {31'd0, ram_we_n}, 32'd1);
        check("rst_oe_n", {31'd0, ram_oe_n}, 32'd1);
        check("rst_ce_n", {31'd0, ram_ce_n}, 32'd1);
        check("rst_lanes", {30'd0, ram_ub_n, ram_lb_n}, 32'd3);
        check("rst_addr", {11'd0, ram_addr}, 32'd0);
        check("rst_bus_drive", {31'd0, dut.drive_q}, 32'd0);
        check("rst_acks", {30'd0, bus_if.a_ack, bus_if.b_ack}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rdata", {bus_if.a_rdata, bus_if.b_rdata}, 32'd0);

        // Both held after reset: A first, B forced after every 4 A grants.
        for (int i = 0; i < 10; i++) begin
            if ((i % 5) == 4) push(1'b1, 16'hB0B0, -1);
            else              push(1'b0, 16'hA0A0, -1);
        end
        tick();
        reset = 1'b0;
        acks = 0;
        for (int i = 0; i < 100 && acks < 10; i++) begin
            @(negedge clock);
            if (bus_if.a_ack || bus_if.b_ack) acks++;
        end
        check("burst_ack_count", acks, 32'd10);
        tick();
        bus_if.a_req = 1'b0;
        bus_if.b_req = 1'b0;
        last_b = 16'hB0B0;

        // B write, low lane only.
        tick();
        bus_if.b_we = 1'b1;
        bus_if.b_be = 2'b01;
        bus_if.b_addr = 21'h000123;
        bus_if.b_wdata = 16'hBEEF;
        bus_if.b_req = 1'b1;
        push(1'b1, last_b, cyc + 3 + W);
        wait_ack(1'b1, we_low, lanes_n, drove);
        check("wr_we_low_cycles", we_low, 32'd2);
        check("wr_lanes_n", {30'd0, lanes_n}, 32'h2);
        tick();
        bus_if.b_req = 1'b0;
        check("wr_mem_word", {16'd0, mem[8'h23]}, 32'h55EF);

        // A read-back of the same word.
        tick();
        bus_if.a_addr = 21'h000123;
        bus_if.a_req = 1'b1;
        push(1'b0, 16'h55EF, cyc + 2 + W);
        wait_ack(1'b0, we_low, lanes_n, drove);
        check("rd_bus_not_driven", {31'd0, drove}, 32'd0);
        check("rd_we_low_cycles", we_low, 32'd0);
        tick();
        bus_if.a_req = 1'b0;

        // B read with req dropped once the access is under way.
        tick();
        bus_if.b_we = 1'b0;
        bus_if.b_be = 2'b11;
        bus_if.b_addr = 21'h000030;
        bus_if.b_req = 1'b1;
        push(1'b1, 16'hC3C3, cyc + 2 + W);
        tick();
        tick();
        bus_if.b_req = 1'b0;
        wait_ack(1'b1, we_low, lanes_n, drove);
        repeat (6) tick();

        // Reset during the ACCESS phase of a write.
        bus_if.b_we = 1'b1;
        bus_if.b_addr = 21'h000040;
        bus_if.b_wdata = 16'h7777;
        bus_if.b_req = 1'b1;
        tick();
        tick();
        #2;
        check("abort_we_active", {31'd0, ram_we_n}, 32'd0);
        reset = 1'b1;
        #1;
        check("abort_we_n", {31'd0, ram_we_n}, 32'd1);
        check("abort_ce_n", {31'd0, ram_ce_n}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_b_ack", {31'd0, bus_if.b_ack}, 32'd0);
        check("abort_bus_drive", {31'd0, dut.drive_q}, 32'd0);
        bus_if.b_req = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        repeat (4) tick();
        check("abort_b_rdata", {16'd0, bus_if.b_rdata}, 32'd0);
        last_b = 16'h0000;

        // Write with no byte enables behaves as a full-word write.
        bus_if.b_we = 1'b1;
        bus_if.b_be = 2'b00;
        bus_if.b_addr = 21'h000050;
        bus_if.b_wdata = 16'h1234;
        bus_if.b_req = 1'b1;
        push(1'b1, last_b, cyc + 3 + W);
        wait_ack(1'b1, we_low, lanes_n, drove);
        check("be00_lanes_n", {30'd0, lanes_n}, 32'd0);
        check("be00_we_low_cycles", we_low, 32'd2);
        tick();
        bus_if.b_req = 1'b0;
        check("be00_mem_word", {16'd0, mem[8'h50]}, 32'h1234);
        tick();
        bus_if.a_addr = 21'h000050;
        bus_if.a_req = 1'b1;
        push(1'b0, 16'h1234, cyc + 2 + W);
        wait_ack(1'b0, we_low, lanes_n, drove);
        tick();
        bus_if.a_req = 1'b0;

        repeat (4) tick();
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the board's single 16-bit asynchronous SRAM (21-bit word address, lb/ub byte lanes) between two requesters.
- Port A is the video/fetch side: high priority, read-only.
- Port B is the CPU/DMA side: read/write with per-byte enables.
- Sits between the core and the ram_* pads and sequences every SRAM cycle: address setup, WE pulse, write recovery, read capture.

Parameters:
- WAIT_CYCLES, 2: clock cycles the access phase lasts (tAA/tWP budget at sysclk); legal 1..15.
- A_BURST_MAX, 4: max consecutive port-A grants while B is pending before B is forced next; legal 1..15.

Ports:
- clock  in  1  system clock (sysclk)
- reset  in  1  asynchronous, active-high reset
- a_req  in  1  port A request; held high until a_ack
- a_addr  in  21  port A word address
- a_ack  out  1  one-cycle pulse; a_rdata valid in the same cycle
- a_rdata  out  16  port A read data
- b_req  in  1  port B request; held high until b_ack
- b_we  in  1  1 = write, 0 = read
- b_be  in  2  byte enables {ub,lb}; 2'b00 is treated as 2'b11
- b_addr  in  21  port B word address
- b_wdata  in  16  port B write data
- b_ack  out  1  one-cycle pulse on completion
- b_rdata  out  16  port B read data, valid with b_ack
- ram_addr_o  out  21  SRAM address
- ram_data_io  inout  16  SRAM data; tri-stated except during writes
- ram_we_n_o  out  1  SRAM write enable, active low
- ram_oe_n_o  out  1  SRAM output enable, active low
- ram_ce_n_o  out  1  SRAM chip enable, active low
- ram_lb_n_o  out  1  lower byte lane enable, active low
- ram_ub_n_o  out  1  upper byte lane enable, active low
- busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset values:
  - FSM in IDLE; ram_we_n_o = 1, ram_oe_n_o = 1, ram_ce_n_o = 1, lb_n = ub_n = 1.
  - ram_addr_o = 0; data bus high-Z.
  - a_ack = b_ack = 0; a_rdata = b_rdata = 0; busy = 0; burst counter = 0.
- All pad outputs are registered; no combinational path from req to pads.
- FSM states: IDLE -> SETUP -> ACCESS -> (RECOVER if write) -> DONE -> IDLE.
- IDLE arbitration:
  - Only a_req: grant A.
  - Only b_req: grant B.
  - Both high: grant A unless burst counter == A_BURST_MAX, in which case grant B.
  - Burst counter increments on each A grant while b_req = 1 and clears on any B grant. It also clears in any IDLE cycle with b_req = 0.
- SETUP (1 cycle):
  - Latch the winning address, we, be and wdata internally.
  - Drive ram_addr_o and ce_n = 0.
  - Read: oe_n = 0, lb_n = ub_n = 0.
  - Write: oe_n = 1, drive ram_data_io, lanes = ~be.
- ACCESS (WAIT_CYCLES cycles, internal down-counter):
  - Write: we_n = 0 for every ACCESS cycle.
  - Read: ram_data_io is sampled in the last ACCESS cycle into the granted port's rdata register.
- RECOVER (writes only, 1 cycle): we_n = 1; address and data still driven (hold time).
- DONE (1 cycle):
  - Pulse the granted ack.
  - ce_n = oe_n = 1, lanes = 1; data bus released to Z.
  - Return to IDLE.
- Latency from req sampled in IDLE to ack:
  - Read: 2 + WAIT_CYCLES cycles.
  - Write: 3 + WAIT_CYCLES cycles.
- Minimum gap between accesses: one IDLE cycle. Back-to-back requests are re-arbitrated in that cycle.
- rdata registers hold their value until that port's next read completes. Writes never change b_rdata.
- A req dropped mid-access does not abort the transaction; ack is still pulsed.
- A requester that keeps req high after ack is served again through normal arbitration.
- b_be = 00 is coerced to 11 at latch time.
- Asynchronous reset mid-access returns immediately to reset values. we_n rises without waiting for RECOVER, and no ack is generated.

Decomposition:
- Shared package: FSM state encoding (IDLE, SETUP, ACCESS, RECOVER, DONE), GRANT_A / GRANT_B constants, WAIT counter width (4 bits).
- One natural sub-module: sram_arb_pick. It is combinational fixed-priority selection plus the registered starvation counter, returning the grant.
- The sequencing FSM and pad registers stay in sram_arbiter.

Test Plan:
- Reset with both reqs high, then release reset:
  - During reset: all pads inactive (we_n/oe_n/ce_n = 1), bus Z, acks 0.
  - After release: first grant goes to A.
- B write, addr 0x00123, be = 01, wdata 0xBEEF, WAIT_CYCLES = 2:
  - we_n low exactly 2 cycles; lb_n = 0, ub_n = 1.
  - b_ack 5 cycles after req.
  - The SRAM model's low byte = 0xEF, high byte unchanged.
- A read of the word just written (model preloaded high byte 0x55):
  - a_ack 4 cycles after req; a_rdata = 0x55EF.
  - Bus never driven by the arbiter during the read.
- a_req and b_req held continuously, A_BURST_MAX = 4:
  - Grant sequence A,A,A,A,B,A,A,A,A,B.
  - No port waits longer than 4 consecutive other-port transactions.
- b_req dropped one cycle after SETUP: access completes and b_ack still pulses once. Then assert reset during ACCESS of a write: we_n returns high asynchronously, no ack, FSM in IDLE.
- b_be = 00 write of 0x1234: both lanes enabled; the model's word reads back 0x1234.
